// File: rtl/pipeline_controller.sv
// -----------------------------------------------------------------------------
// pipeline_controller
//
// Central sequencer for the five-stage pipeline (fetch / decode / execute /
// memory access / writeback). Produces the per-stage buffer write enables,
// the IF/ID flush and the ID/EX / MEM/WB bubble controls from decode hazard
// information and the data-memory handshake. Also provides a debug
// halt / single-step / resume mode and a memory-wait timeout fault.
//
// Configuration macro:
//   PERF_COUNTER_EN  defined     -> stallCycles / flushCount are saturating
//                                   performance counters.
//                    not defined -> both outputs are tied to zero and no
//                                   counter flops exist.
//
// Parameters:
//   MEM_TIMEOUT  max consecutive memory-wait cycles before FAULT (2..255)
//   COUNT_WIDTH  width of the performance counters
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   idRs, idRt             source register fields of the instruction in decode
//   idUsesRs, idUsesRt     decode instruction actually reads rs / rt
//   idExMemRead, idExRt    execute holds a load targeting idExRt
//   branchTaken            execute resolved a taken branch/jump this cycle
//   memRequest, memReady   memory-access stage handshake
//   haltRequest            debug halt pulse
//   stepRequest            debug single-step pulse (HALT only)
//   resumeRequest          debug resume pulse (HALT only)
//   pcWrite .. memWbBubble per-stage enables / flush / bubble controls
//   state                  RUN=0, MEM_WAIT=1, HALT=2, FAULT=3
//   fault                  high while in FAULT
//   stallCycles            cycles with pcWrite=0 outside HALT/FAULT
//   flushCount             number of cycles with ifIdFlush=1
// -----------------------------------------------------------------------------
module pipeline_controller #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             idRs,
  input  logic [4:0]             idRt,
  input  logic                   idUsesRs,
  input  logic                   idUsesRt,
  input  logic                   idExMemRead,
  input  logic [4:0]             idExRt,
  input  logic                   branchTaken,
  input  logic                   memRequest,
  input  logic                   memReady,
  input  logic                   haltRequest,
  input  logic                   stepRequest,
  input  logic                   resumeRequest,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   ifIdFlush,
  output logic                   idExWrite,
  output logic                   idExBubble,
  output logic                   exMemWrite,
  output logic                   memWbBubble,
  output logic [1:0]             state,
  output logic                   fault,
  output logic [COUNT_WIDTH-1:0] stallCycles,
  output logic [COUNT_WIDTH-1:0] flushCount
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2,
    ST_FAULT    = 2'd3
  } state_e;

  // Bundle of all pipeline controls, in output port order.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctl_t;

  localparam ctl_t CTL_ALL      = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  // Freezes every stage and drains a bubble into writeback; also the HALT set.
  localparam ctl_t CTL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctl_t CTL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  // Value the wait counter holds on the last permitted wait cycle.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       step_pending_q, step_pending_d;
  logic       halt_latched_q, halt_latched_d;
  logic       fault_q, fault_d;

  logic load_use;
  logic mem_stall;
  ctl_t run_ctl;
  ctl_t ctl;

  // ---------------------------------------------------------------------------
  // Hazard detection and control generation
  // ---------------------------------------------------------------------------
  always_comb begin
    load_use  = idExMemRead && (idExRt != 5'd0) &&
                ((idUsesRs && (idRs == idExRt)) || (idUsesRt && (idRt == idExRt)));
    mem_stall = memRequest && !memReady;

    // Branch beats load-use: the dependent instruction is wrong-path anyway.
    if (mem_stall)        run_ctl = CTL_FREEZE;
    else if (branchTaken) run_ctl = CTL_BRANCH;
    else if (load_use)    run_ctl = CTL_LOAD_USE;
    else                  run_ctl = CTL_ALL;

    // NOTE: every variable assigned in always_comb gets a value on every path
    // (here via the default arm) so no latch is inferred.
    unique case (state_q)
      ST_RUN:      ctl = run_ctl;
      // On the completing cycle mem_stall is already low, so the RUN priority
      // lets the access retire while a branch held in execute is re-evaluated.
      ST_MEM_WAIT: ctl = memReady ? run_ctl : CTL_FREEZE;
      ST_HALT:     ctl = step_pending_q ? run_ctl : CTL_FREEZE;
      default:     ctl = CTL_FREEZE;
    endcase
  end

  assign pcWrite     = ctl.pc_write;
  assign ifIdWrite   = ctl.if_id_write;
  assign ifIdFlush   = ctl.if_id_flush;
  assign idExWrite   = ctl.id_ex_write;
  assign idExBubble  = ctl.id_ex_bubble;
  assign exMemWrite  = ctl.ex_mem_write;
  assign memWbBubble = ctl.mem_wb_bubble;
  assign state       = state_q;
  assign fault       = fault_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    step_pending_d = step_pending_q;
    halt_latched_d = halt_latched_q;

    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d        = ST_MEM_WAIT;
          wait_cnt_d     = 8'd1;
          halt_latched_d = haltRequest;   // keep a halt pulse that hits a stall
        end else if (haltRequest) begin
          state_d = ST_HALT;
        end
      end

      ST_MEM_WAIT: begin
        if (memReady) begin
          state_d        = (halt_latched_q || haltRequest) ? ST_HALT : ST_RUN;
          wait_cnt_d     = 8'd0;
          halt_latched_d = 1'b0;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d        = ST_FAULT;
          halt_latched_d = 1'b0;
        end else begin
          wait_cnt_d     = wait_cnt_q + 8'd1;
          halt_latched_d = halt_latched_q || haltRequest;
        end
      end

      ST_HALT: begin
        if (step_pending_q) begin
          // The single step cycle: behaves as RUN, then falls back to HALT.
          step_pending_d = 1'b0;
          if (mem_stall) begin
            state_d        = ST_MEM_WAIT;
            wait_cnt_d     = 8'd1;
            halt_latched_d = 1'b1;
          end else if (resumeRequest) begin
            state_d = ST_RUN;
          end else begin
            step_pending_d = stepRequest;
          end
        end else if (resumeRequest) begin
          state_d = ST_RUN;               // resume wins over a coincident step
        end else if (stepRequest) begin
          step_pending_d = 1'b1;
        end
      end

      default: ;                          // FAULT: only reset leaves
    endcase

    fault_d = (state_d == ST_FAULT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= 8'd0;
      step_pending_q <= 1'b0;
      halt_latched_q <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      step_pending_q <= step_pending_d;
      halt_latched_q <= halt_latched_d;
      fault_q        <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
`ifdef PERF_COUNTER_EN
  logic [COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [COUNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctl.pc_write && (state_q == ST_RUN || state_q == ST_MEM_WAIT) &&
        (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (ctl.if_id_flush && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stallCycles = stall_cnt_q;
  assign flushCount  = flush_cnt_q;
`else
  assign stallCycles = '0;
  assign flushCount  = '0;
`endif

endmodule
